// File: rtl/ps2_threshold_config.sv
// Keyboard-driven threshold configuration: filters PS/2 make codes, runs the
// select/digit/confirm dialogue and holds the committed low/high thresholds.
module ps2_threshold_config #(
  parameter logic [2:0]  LOW_DEFAULT    = 3'd4,
  parameter logic [2:0]  HIGH_DEFAULT   = 3'd6,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
  parameter int unsigned TW             = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] scan_code,
  output logic [2:0] thr_low,
  output logic [2:0] thr_high,
  output logic [1:0] cfg_state,
  output logic [2:0] pend_digit,
  output logic       commit,
  output logic       err
);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEL  = 2'b01,
    DIG  = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic          target_q, target_d;
  logic [2:0]    pend_q, pend_d;
  logic [2:0]    low_q, low_d;
  logic [2:0]    high_q, high_d;
  logic          commit_q, commit_d;
  logic          err_q, err_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic [TW-1:0] timer_q, timer_d;

  logic       plain;
  logic       is_digit;
  logic [2:0] digit;
  logic       is_l, is_h, is_enter, is_esc;
  logic       key;

  // Key decode: only plain make codes from the recognised key set count.
  always_comb begin
    plain    = rx_done && !brk_q && !ext_q &&
               (scan_code != 8'hF0) && (scan_code != 8'hE0);
    is_digit = 1'b1;
    digit    = 3'd0;
    case (scan_code)
      8'h45:   digit = 3'd0;
      8'h16:   digit = 3'd1;
      8'h1E:   digit = 3'd2;
      8'h26:   digit = 3'd3;
      8'h25:   digit = 3'd4;
      8'h2E:   digit = 3'd5;
      8'h36:   digit = 3'd6;
      8'h3D:   digit = 3'd7;
      default: is_digit = 1'b0;
    endcase
    is_l     = (scan_code == 8'h4B);
    is_h     = (scan_code == 8'h33);
    is_enter = (scan_code == 8'h5A);
    is_esc   = (scan_code == 8'h76);
    key      = plain && (is_digit || is_l || is_h || is_enter || is_esc);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      target_q <= 1'b0;
      pend_q   <= 3'd0;
      low_q    <= LOW_DEFAULT;
      high_q   <= HIGH_DEFAULT;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      pend_q   <= pend_d;
      low_q    <= low_d;
      high_q   <= high_d;
      commit_q <= commit_d;
      err_q    <= err_d;
      brk_q    <= brk_d;
      ext_q    <= ext_d;
      timer_q  <= timer_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    pend_d   = pend_q;
    low_d    = low_q;
    high_d   = high_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
    brk_d    = brk_q;
    ext_d    = ext_q;
    timer_d  = timer_q;

    // Prefix flags swallow exactly one following non-prefix byte.
    if (rx_done) begin
      if (scan_code == 8'hF0) begin
        brk_d = 1'b1;
      end else if (scan_code == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end

    if (key) begin
      timer_d = '0;
      case (state_q)
        IDLE: begin
          if (is_l || is_h) begin
            state_d  = SEL;
            target_d = is_h;
          end
        end
        SEL: begin
          if (is_digit) begin
            state_d = DIG;
            pend_d  = digit;
          end else if (is_l || is_h) begin
            target_d = is_h;
          end else if (is_esc) begin
            state_d = IDLE;
          end
        end
        DIG: begin
          if (is_digit) begin
            pend_d = digit;
          end else if (is_l || is_h) begin
            target_d = is_h;
          end else if (is_esc) begin
            state_d = IDLE;
            pend_d  = 3'd0;
          end else if (is_enter) begin
            state_d = IDLE;
            pend_d  = 3'd0;
            // Accept only values that keep low strictly below high.
            if (!target_q && (pend_q < high_q)) begin
              low_d    = pend_q;
              commit_d = 1'b1;
            end else if (target_q && (pend_q > low_q)) begin
              high_d   = pend_q;
              commit_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          pend_d  = 3'd0;
        end
      endcase
    end else if (state_q != IDLE) begin
      if (timer_q == TIMER_LAST) begin
        state_d = IDLE;
        pend_d  = 3'd0;
        err_d   = 1'b1;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  assign thr_low    = low_q;
  assign thr_high   = high_q;
  assign cfg_state  = state_q;
  assign pend_digit = pend_q;
  assign commit     = commit_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ps2_threshold_config.sv
// Scoreboard bench for ps2_threshold_config: a behavioural dialogue model
// predicts every output cycle; predictions are queued and compared after each edge.
module tb_ps2_threshold_config;

  localparam int unsigned TO = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done;
  logic [7:0] scan_code;
  logic [2:0] thr_low, thr_high, pend_digit;
  logic [1:0] cfg_state;
  logic       commit, err;

  ps2_threshold_config #(
    .LOW_DEFAULT   (3'd4),
    .HIGH_DEFAULT  (3'd6),
    .TIMEOUT_CYCLES(TO),
    .TW            (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_done   (rx_done),
    .scan_code (scan_code),
    .thr_low   (thr_low),
    .thr_high  (thr_high),
    .cfg_state (cfg_state),
    .pend_digit(pend_digit),
    .commit    (commit),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of the dialogue
  logic [7:0] digit_codes [8] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D};
  logic [2:0] m_low, m_high, m_pend;
  logic [1:0] m_state;
  logic       m_commit, m_err, m_tgt, m_brk, m_ext;
  int         m_timer;
  logic [12:0] sb[$];

  task automatic model_reset();
    m_low = 3'd4; m_high = 3'd6; m_pend = 3'd0; m_state = 2'b00;
    m_commit = 1'b0; m_err = 1'b0; m_tgt = 1'b0; m_brk = 1'b0; m_ext = 1'b0;
    m_timer = 0;
  endtask

  task automatic model_step(input logic rx, input logic [7:0] c);
    logic hit, dig, lk, hk, ent, esc;
    logic [2:0] v;
    m_commit = 1'b0; m_err = 1'b0;
    hit = 1'b0; dig = 1'b0; v = 3'd0;
    lk = (c == 8'h4B); hk = (c == 8'h33); ent = (c == 8'h5A); esc = (c == 8'h76);
    if (rx) begin
      if (c == 8'hF0) m_brk = 1'b1;
      else if (c == 8'hE0) m_ext = 1'b1;
      else if (m_brk || m_ext) begin
        m_brk = 1'b0; m_ext = 1'b0;
      end else begin
        for (int i = 0; i < 8; i++) if (c == digit_codes[i]) begin dig = 1'b1; v = 3'(i); end
        hit = dig || lk || hk || ent || esc;
        if (hit) begin
          m_timer = 0;
          if (m_state == 2'b00) begin
            if (lk || hk) begin m_state = 2'b01; m_tgt = hk; end
          end else if (m_state == 2'b01) begin
            if (dig) begin m_state = 2'b10; m_pend = v; end
            else if (lk || hk) m_tgt = hk;
            else if (esc) m_state = 2'b00;
          end else begin
            if (dig) m_pend = v;
            else if (lk || hk) m_tgt = hk;
            else if (esc) begin m_state = 2'b00; m_pend = 3'd0; end
            else if (ent) begin
              if (m_tgt == 1'b0) begin
                if (m_pend < m_high) begin m_low = m_pend; m_commit = 1'b1; end
                else m_err = 1'b1;
              end else begin
                if (m_pend > m_low) begin m_high = m_pend; m_commit = 1'b1; end
                else m_err = 1'b1;
              end
              m_state = 2'b00; m_pend = 3'd0;
            end
          end
        end
      end
    end
    if (!hit && m_state != 2'b00) begin
      if (m_timer == int'(TO) - 1) begin
        m_state = 2'b00; m_pend = 3'd0; m_err = 1'b1; m_timer = 0;
      end else begin
        m_timer++;
      end
    end
  endtask

  function automatic logic [12:0] model_vec();
    return {m_low, m_high, m_state, m_pend, m_commit, m_err};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {thr_low, thr_high, cfg_state, pend_digit, commit, err};
  endfunction

  // One clock: drive on the falling edge, predict, compare after the rising edge.
  task automatic tick(input logic rx, input logic [7:0] c, input string tag);
    @(negedge clk);
    rx_done = rx; scan_code = c;
    model_step(rx, c);
    sb.push_back(model_vec());
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    if (sb.size() == 0) check({tag, "_sb_underflow"}, 32'd1, 32'd0);
    else check(tag, 32'(dut_vec()), 32'(sb.pop_front()));
    check({tag, "_excl"}, 32'(commit & err), 32'd0);
  endtask

  task automatic send(input logic [7:0] c, input string tag);
    tick(1'b1, c, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, tag);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; rx_done = 1'b0; scan_code = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_vec", 32'(dut_vec()), 32'(model_vec()));
    check("rst_low", 32'(thr_low), 32'd4);
    check("rst_high", 32'(thr_high), 32'd6);
    reset = 1'b1;
    idle(20, "idle_after_reset");
    check("idle_low", 32'(thr_low), 32'd4);

    // Low threshold commit with break codes interleaved
    send(8'h4B, "lo_sel");
    check("lo_sel_state", 32'(cfg_state), 32'd1);
    send(8'hF0, "lo_brk");  send(8'h4B, "lo_brk_disc");
    send(8'h26, "lo_dig");
    check("lo_dig_pend", 32'(pend_digit), 32'd3);
    send(8'hF0, "lo_brk2"); send(8'h26, "lo_brk2_disc");
    send(8'h5A, "lo_enter");
    check("lo_commit", 32'(commit), 32'd1);
    idle(2, "lo_post");
    check("lo_value", 32'(thr_low), 32'd3);

    // High threshold: rejected then accepted
    send(8'h33, "hi_sel"); send(8'h1E, "hi_dig2"); send(8'h5A, "hi_enter_bad");
    check("hi_err", 32'(err), 32'd1);
    send(8'h33, "hi_sel2"); send(8'h3D, "hi_dig7"); send(8'h5A, "hi_enter_ok");
    check("hi_value", 32'(thr_high), 32'd7);

    // Boundaries: low == high and high == low both rejected; retarget keeps digit
    send(8'h4B, "eq_sel"); send(8'h3D, "eq_dig7"); send(8'h5A, "eq_lo_enter");
    send(8'h33, "eq_sel_h"); send(8'h26, "eq_dig3"); send(8'h4B, "eq_retarget");
    send(8'h33, "eq_retarget_h"); send(8'h5A, "eq_hi_enter");
    send(8'h4B, "ig_sel"); send(8'h5A, "ig_enter_in_sel"); send(8'h1C, "ig_other");
    send(8'h76, "ig_esc");

    // Timeout expires exactly TO cycles after the last key
    send(8'h4B, "to_sel"); send(8'h36, "to_dig");
    idle(TO, "to_wait");
    check("to_state", 32'(cfg_state), 32'd0);
    check("to_low", 32'(thr_low), 32'd3);
    // Key on the expiry cycle wins
    send(8'h4B, "tk_sel"); send(8'h36, "tk_dig");
    idle(TO - 1, "tk_wait");
    send(8'h3D, "tk_key_on_expiry");
    check("tk_state", 32'(cfg_state), 32'd2);
    idle(5, "tk_after");

    // Extended/break prefixes discarded, Esc aborts
    send(8'h76, "ex_esc0");
    send(8'hE0, "ex_e0"); send(8'hF0, "ex_f0"); send(8'h4B, "ex_disc1");
    send(8'hE0, "ex_e0b"); send(8'h4B, "ex_disc2");
    send(8'h4B, "ex_sel"); send(8'h2E, "ex_dig5"); send(8'h76, "ex_esc");
    idle(3, "ex_post");

    // Asynchronous reset mid-dialogue
    send(8'h4B, "ar_sel"); send(8'h25, "ar_dig");
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("ar_async_vec", 32'(dut_vec()), 32'(model_vec()));
    check("ar_async_low", 32'(thr_low), 32'd4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    send(8'h5A, "ar_enter_alone");
    idle(3, "ar_post");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
